// File: rtl/pipelined_addsub_pkg.sv
// Shared constants and helpers for the pipelined add/subtract unit.
// Saturation bounds are built wide, then truncated to WIDTH by the user.
package pipelined_addsub_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;
  localparam int MAX_W      = 1024;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic logic [MAX_W-1:0] smin(input int width);
    logic [MAX_W-1:0] one;
    one = MAX_W'(1);
    return one << (width - 1);
  endfunction

  function automatic logic [MAX_W-1:0] smax(input int width);
    return smin(width) - MAX_W'(1);
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational W-bit ripple-carry adder built from full-adder cells.
module addsub_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_full_adder
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[W];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: one CHUNK-bit ripple per stage, carry registered between stages.
// Optional saturation on signed overflow when PIPELINED_ADDSUB_SAT_EN is defined (adds port sat).
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef PIPELINED_ADDSUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);

`ifdef PIPELINED_ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(smax(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(smin(WIDTH));
`endif

  logic             adv;
  logic [STAGES-1:0] v_q, vin;
  logic [STAGES-1:0] c_q, c_in, c_nxt;
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] a_in  [STAGES];
  logic [WIDTH-1:0] b_in  [STAGES];
  logic [WIDTH-1:0] s_in  [STAGES];
  logic [WIDTH-1:0] s_nxt [STAGES];
  logic             ovf_q, ovf_nxt;
`ifdef PIPELINED_ADDSUB_SAT_EN
  logic [STAGES-1:0] sat_q, sat_in;
`endif

  assign adv      = !v_q[STAGES-1] || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] chunk_s;

    if (k == 0) begin : g_first
      // Subtraction folds into addition: invert B here and force the carry-in.
      assign vin[0]  = in_valid;
      assign a_in[0] = a;
      assign b_in[0] = sub ? ~b : b;
      assign c_in[0] = sub | cin;
      assign s_in[0] = '0;
`ifdef PIPELINED_ADDSUB_SAT_EN
      assign sat_in[0] = sat;
`endif
    end else begin : g_next
      assign vin[k]  = v_q[k-1];
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign s_in[k] = s_q[k-1];
`ifdef PIPELINED_ADDSUB_SAT_EN
      assign sat_in[k] = sat_q[k-1];
`endif
    end

    addsub_chunk #(.W(CHUNK)) u_chunk (
      .a    (a_in[k][k*CHUNK +: CHUNK]),
      .b    (b_in[k][k*CHUNK +: CHUNK]),
      .cin  (c_in[k]),
      .sum  (chunk_s),
      .cout (c_nxt[k])
    );

    // Bits above the current chunk are still zero, so OR-ing inserts the chunk.
    if (k < STAGES - 1) begin : g_mid
      assign s_nxt[k] = s_in[k] | (WIDTH'(chunk_s) << (k * CHUNK));
    end else begin : g_last
      logic [WIDTH-1:0] wrap;
      assign wrap    = s_in[k] | (WIDTH'(chunk_s) << (k * CHUNK));
      assign ovf_nxt = (a_in[k][WIDTH-1] == b_in[k][WIDTH-1]) &&
                       (wrap[WIDTH-1] != a_in[k][WIDTH-1]);
`ifdef PIPELINED_ADDSUB_SAT_EN
      assign s_nxt[k] = (sat_in[k] && ovf_nxt) ?
                        (a_in[k][WIDTH-1] ? SAT_MIN : SAT_MAX) : wrap;
`else
      assign s_nxt[k] = wrap;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
`ifdef PIPELINED_ADDSUB_SAT_EN
      sat_q <= '0;
`endif
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      v_q <= vin;
      // Data only moves with a valid beat so bubbles leave results untouched.
      for (int k = 0; k < STAGES; k++) begin
        if (vin[k]) begin
          a_q[k] <= a_in[k];
          b_q[k] <= b_in[k];
          s_q[k] <= s_nxt[k];
          c_q[k] <= c_nxt[k];
`ifdef PIPELINED_ADDSUB_SAT_EN
          sat_q[k] <= sat_in[k];
`endif
        end
      end
      if (vin[STAGES-1]) ovf_q <= ovf_nxt;
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed self-checking bench for pipelined_addsub (WIDTH=32, STAGES=4).
module tb_pipelined_addsub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        sat = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
  logic        cout;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
`ifdef PIPELINED_ADDSUB_SAT_EN
    .sat       (sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  // Drives one beat and waits for its result; lat = negedges from accept edge, -1 on timeout.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tcin,
                        input logic tsub, input logic tsat, output logic [31:0] osum,
                        output logic ocout, output logic oovf, output int lat);
    @(posedge clk); #1;
    a = ta; b = tb_v; cin = tcin; sub = tsub; sat = tsat; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (lat > 20) begin lat = -1; break; end
    end
    osum = sum; ocout = cout; oovf = overflow;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (sum !== 32'h0) begin errors++; $display("FAIL reset_sum got %h want 00000000", sum); end
    checks++; if ({cout, overflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {cout, overflow}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_carry_chain();
    logic [31:0] s; logic c, o; int lat;
    run_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, s, c, o, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL carry_latency got %0d want 4", lat); end
    checks++; if ({s, c, o} !== {32'h0, 1'b1, 1'b0}) begin errors++; $display("FAIL carry_chain got %h c%b o%b want 00000000 c1 o0", s, c, o); end
  endtask

  task automatic test_subtract();
    logic [31:0] s; logic c, o; int lat;
    run_op(32'd5, 32'd7, 1'b0, 1'b1, 1'b0, s, c, o, lat);
    checks++; if ({s, c, o} !== {32'hFFFF_FFFE, 1'b0, 1'b0}) begin errors++; $display("FAIL sub_5_7 got %h c%b o%b want fffffffe c0 o0", s, c, o); end
    run_op(32'd7, 32'd5, 1'b0, 1'b1, 1'b0, s, c, o, lat);
    checks++; if ({s, c, o} !== {32'h2, 1'b1, 1'b0}) begin errors++; $display("FAIL sub_7_5 got %h c%b o%b want 00000002 c1 o0", s, c, o); end
    run_op(32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b0, s, c, o, lat);
    checks++; if ({s, c, o} !== {32'h7FFF_FFFF, 1'b1, 1'b1}) begin errors++; $display("FAIL sub_min_1 got %h c%b o%b want 7fffffff c1 o1", s, c, o); end
  endtask

  task automatic test_overflow();
    logic [31:0] s; logic c, o; int lat;
    run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, s, c, o, lat);
    checks++; if ({s, c, o} !== {32'h8000_0000, 1'b0, 1'b1}) begin errors++; $display("FAIL ovf_wrap got %h c%b o%b want 80000000 c0 o1", s, c, o); end
`ifdef PIPELINED_ADDSUB_SAT_EN
    run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, s, c, o, lat);
    checks++; if ({s, c, o} !== {32'h7FFF_FFFF, 1'b0, 1'b1}) begin errors++; $display("FAIL ovf_sat_pos got %h c%b o%b want 7fffffff c0 o1", s, c, o); end
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, s, c, o, lat);
    checks++; if ({s, c, o} !== {32'h8000_0000, 1'b1, 1'b1}) begin errors++; $display("FAIL ovf_sat_neg got %h c%b o%b want 80000000 c1 o1", s, c, o); end
`endif
  endtask

  task automatic test_cin();
    logic [31:0] s; logic c, o; int lat;
    run_op(32'h0000_FFFF, 32'h0, 1'b1, 1'b0, 1'b0, s, c, o, lat);
    checks++; if ({s, c} !== {32'h0001_0000, 1'b0}) begin errors++; $display("FAIL cin_add got %h c%b want 00010000 c0", s, c); end
    run_op(32'd1, 32'd1, 1'b1, 1'b1, 1'b0, s, c, o, lat);
    checks++; if ({s, c, o} !== {32'h0, 1'b1, 1'b0}) begin errors++; $display("FAIL cin_ignored got %h c%b o%b want 00000000 c1 o0", s, c, o); end
  endtask

  task automatic test_back_to_back();
    int cyc = 0, idx = 0, got = 0, extra = 0;
    logic acc;
    logic [31:0] held = '0;
    @(posedge clk); #1;
    while (got < 8 && cyc < 60) begin
      out_ready = !(cyc >= 6 && cyc <= 8);
      in_valid  = (idx < 8);
      a = idx + 1; b = idx; cin = 1'b0; sub = 1'b0; sat = 1'b0;
      @(negedge clk);
      if (!out_ready) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc %0d got %b want 0", cyc, in_ready); end
        if (cyc == 6) held = sum;
        else begin
          checks++; if (sum !== held) begin errors++; $display("FAIL stall_hold cyc %0d got %h want %h", cyc, sum, held); end
        end
      end
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        checks++; if (sum !== 32'(2 * got + 1)) begin errors++; $display("FAIL stream_sum beat %0d got %h want %h", got, sum, 32'(2 * got + 1)); end
        got++;
      end
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got !== 8) begin errors++; $display("FAIL stream_count got %0d want 8", got); end
    repeat (6) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL stream_extra got %0d want 0", extra); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] s; logic c, o; int lat, wait_n = 0, stray = 0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'h0000_0001; b = 32'h0000_0002;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && wait_n < 20) begin @(negedge clk); wait_n++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %b want 1", out_valid); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %b want 0", out_valid); end
    checks++; if ({sum, cout, overflow} !== 34'h0) begin errors++; $display("FAIL rst_async_data got %h c%b o%b want 0", sum, cout, overflow); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL rst_stale got %0d want 0", stray); end
    run_op(32'd100, 32'd23, 1'b0, 1'b0, 1'b0, s, c, o, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rst_new_latency got %0d want 4", lat); end
    checks++; if (s !== 32'd123) begin errors++; $display("FAIL rst_new_sum got %h want 0000007b", s); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_carry_chain();
    test_subtract();
    test_overflow();
    test_cin();
    test_back_to_back();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
